// File: rtl/z380_waitgen_mc.sv
// z380_waitgen_mc: multi-channel Z380 wait-state generator with CSR-programmed wait profiles
module z380_waitgen_mc #(
  parameter int CHANNELS = 2,
  parameter int PROFILE_COUNT = 8,
  parameter int COUNT_W = 8,
  parameter int INDEX_W = (PROFILE_COUNT < 2) ? 1 : $clog2(PROFILE_COUNT),
  parameter int TMO_W = 16,
  parameter logic [31:0] CSR_BASE = 32'h00a2_2000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         req_valid,
  input  logic [CHANNELS*INDEX_W-1:0] req_profile,
  input  logic [CHANNELS-1:0]         req_burst,
  input  logic [CHANNELS-1:0]         ext_wait_n,
  output logic [CHANNELS-1:0]         req_ready,
  output logic [CHANNELS-1:0]         wait_active,
  output logic [CHANNELS-1:0]         wait_done,
  output logic [CHANNELS-1:0]         wait_err,
  input  logic                        csr_req_valid,
  output logic                        csr_req_ready,
  input  logic                        csr_req_write,
  input  logic [31:0]                 csr_req_addr,
  input  logic [31:0]                 csr_req_wdata,
  output logic                        csr_rsp_valid,
  input  logic                        csr_rsp_ready,
  output logic [31:0]                 csr_rsp_rdata,
  output logic                        csr_rsp_fault,
  output logic                        csr_rsp_side_effect
);
  typedef enum logic [1:0] {IDLE, COUNT, EXT} state_t;
  logic [COUNT_W-1:0] lead [PROFILE_COUNT];
  logic [COUNT_W-1:0] burst [PROFILE_COUNT];
  logic [PROFILE_COUNT-1:0] ext_en;
  logic [TMO_W-1:0] tmo;
  logic [CHANNELS-1:0] sticky, tmo_hit, clr;
  logic [31:0] off, rd;
  logic [INDEX_W-1:0] cidx;
  logic hit_prof, hit_tmo, hit_stat, mapped, fire, unused_bits;
  assign csr_req_ready = !csr_rsp_valid;
  assign fire = csr_req_valid && csr_req_ready;
  assign off = csr_req_addr - CSR_BASE;
  assign cidx = off[2 +: INDEX_W];
  assign hit_prof = off[1:0] == 2'b00 && off < 32'(4 * PROFILE_COUNT);
  assign hit_tmo = off == 32'h40;
  assign hit_stat = off == 32'h44;
  assign mapped = hit_prof || hit_tmo || hit_stat;
  assign unused_bits = ^csr_req_wdata;
  assign rd = hit_prof ? {ext_en[cidx], 15'b0, 8'(burst[cidx]), 8'(lead[cidx])} :
              hit_tmo  ? 32'(tmo) :
              hit_stat ? (32'(wait_active) | (32'(sticky) << 16)) : '0;
  assign clr = (fire && csr_req_write && hit_stat) ? csr_req_wdata[16 +: CHANNELS] : '0;
  // CSR register file, sticky timeout flags and the registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lead <= '{default: '0};
      burst <= '{default: '0};
      ext_en <= '0;
      tmo <= '0;
      sticky <= '0;
      csr_rsp_valid <= 1'b0;
      csr_rsp_rdata <= '0;
      csr_rsp_fault <= 1'b0;
      csr_rsp_side_effect <= 1'b0;
    end else begin
      sticky <= (sticky & ~clr) | tmo_hit;
      if (fire) begin
        csr_rsp_valid <= 1'b1;
        csr_rsp_fault <= !mapped;
        csr_rsp_rdata <= csr_req_write ? '0 : rd;
        csr_rsp_side_effect <= csr_req_write;
        if (csr_req_write && hit_prof) begin
          lead[cidx] <= csr_req_wdata[COUNT_W-1:0];
          burst[cidx] <= csr_req_wdata[8 +: COUNT_W];
          ext_en[cidx] <= csr_req_wdata[31];
        end
        if (csr_req_write && hit_tmo) tmo <= csr_req_wdata[TMO_W-1:0];
      end else if (csr_rsp_valid && csr_rsp_ready) begin
        csr_rsp_valid <= 1'b0;
      end
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : ch
    state_t st;
    logic [COUNT_W-1:0] ctr, n;
    logic [TMO_W-1:0] tc, tl;
    logic [INDEX_W-1:0] p;
    logic pv, xe, xen, done_r, err_r;
    assign p = req_profile[g*INDEX_W +: INDEX_W];
    assign pv = 32'(p) < PROFILE_COUNT;
    assign n = !pv ? '0 : req_burst[g] ? burst[p] : lead[p];
    assign xen = pv && ext_en[p];
    assign req_ready[g] = st == IDLE;
    assign wait_active[g] = st != IDLE;
    assign wait_done[g] = done_r;
    assign wait_err[g] = err_r;
    assign tmo_hit[g] = st == EXT && !ext_wait_n[g] && tl != '0 && tc == tl - 1'b1;
    // Per-channel wait sequencer: lead/burst countdown followed by an optional external stretch
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st <= IDLE;
        ctr <= '0;
        tc <= '0;
        tl <= '0;
        xe <= 1'b0;
        done_r <= 1'b0;
        err_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        err_r <= 1'b0;
        case (st)
          IDLE: if (req_valid[g]) begin
            xe <= xen;
            tc <= '0;
            tl <= tmo;
            ctr <= n;
            st <= n != '0 ? COUNT : xen ? EXT : IDLE;
            done_r <= n == '0 && !xen;
          end
          COUNT: begin
            ctr <= ctr - 1'b1;
            if (ctr == COUNT_W'(1)) begin
              st <= (xe && !ext_wait_n[g]) ? EXT : IDLE;
              done_r <= !(xe && !ext_wait_n[g]);
              tc <= '0;
              tl <= tmo;
            end
          end
          EXT: begin
            tc <= tc + 1'b1;
            if (ext_wait_n[g] || tmo_hit[g]) begin
              st <= IDLE;
              done_r <= 1'b1;
              err_r <= tmo_hit[g];
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_z380_waitgen_mc.sv
// tb_z380_waitgen_mc: directed and randomized checks of the multi-channel wait generator
module tb_z380_waitgen_mc;
  localparam int CH = 2, PC = 8, IW = 3;
  localparam logic [31:0] BASE = 32'h00a2_2000;
  logic clk = 0, rst_n = 0;
  logic [CH-1:0] req_valid = '0, req_burst = '0, ext_wait_n = '1;
  logic [CH*IW-1:0] req_profile = '0;
  logic [CH-1:0] req_ready, wait_active, wait_done, wait_err;
  logic csr_req_valid = 0, csr_req_write = 0, csr_rsp_ready = 1;
  logic [31:0] csr_req_addr = '0, csr_req_wdata = '0;
  logic csr_req_ready, csr_rsp_valid, csr_rsp_fault, csr_rsp_side_effect;
  logic [31:0] csr_rsp_rdata;
  int vec = 0, errs = 0, cyc = 0;
  int ps[CH], pe[CH], pd[CH], ls[CH], le[CH];
  bit perr[CH];
  logic [7:0] ml[PC], mb[PC];
  bit me[PC];
  int tmo_m;
  logic [31:0] sticky_m;

  always #5 clk = ~clk;

  z380_waitgen_mc dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_profile(req_profile),
    .req_burst(req_burst), .ext_wait_n(ext_wait_n), .req_ready(req_ready),
    .wait_active(wait_active), .wait_done(wait_done), .wait_err(wait_err),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready), .csr_req_write(csr_req_write),
    .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata), .csr_rsp_valid(csr_rsp_valid),
    .csr_rsp_ready(csr_rsp_ready), .csr_rsp_rdata(csr_rsp_rdata), .csr_rsp_fault(csr_rsp_fault),
    .csr_rsp_side_effect(csr_rsp_side_effect)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ps[c] = 1; pe[c] = 0; pd[c] = -1; ls[c] = 0; le[c] = 0; perr[c] = 0;
    end
    for (int i = 0; i < PC; i++) begin
      ml[i] = 0; mb[i] = 0; me[i] = 0;
    end
    tmo_m = 0;
    sticky_m = 0;
  endtask

  function automatic int first_high(int c, int x);
    return (x >= ls[c] && x < le[c]) ? le[c] : x;
  endfunction

  // advance one clock, drive ext_wait_n from each channel's low window, check every channel
  task automatic tick();
    bit act, dn;
    @(posedge clk);
    #1;
    cyc++;
    req_valid = '0;
    csr_req_valid = 0;
    for (int c = 0; c < CH; c++) begin
      ext_wait_n[c] = !(cyc >= ls[c] && cyc < le[c]);
      act = cyc >= ps[c] && cyc <= pe[c];
      dn = cyc == pd[c];
      chk($sformatf("wait_active%0d", c), 32'(wait_active[c]), 32'(act));
      chk($sformatf("req_ready%0d", c), 32'(req_ready[c]), 32'(!act));
      chk($sformatf("wait_done%0d", c), 32'(wait_done[c]), 32'(dn));
      chk($sformatf("wait_err%0d", c), 32'(wait_err[c]), 32'(dn && perr[c]));
    end
  endtask

  // request in the current cycle; ext_wait_n is held low for lo cycles starting next cycle
  task automatic issue(int c, int p, bit b, int lo);
    int n, t, es, h;
    bit en;
    t = cyc;
    req_valid[c] = 1;
    req_profile[c*IW +: IW] = IW'(p);
    req_burst[c] = b;
    ls[c] = t + 1;
    le[c] = t + 1 + lo;
    n = b ? int'(mb[p]) : int'(ml[p]);
    en = me[p];
    perr[c] = 0;
    ps[c] = t + 1;
    if (!en || (n > 0 && first_high(c, t + n) == t + n)) pd[c] = t + n + 1;
    else begin
      es = t + n + 1;
      h = first_high(c, es);
      if (tmo_m != 0 && es + tmo_m - 1 < h) begin
        pd[c] = es + tmo_m;
        perr[c] = 1;
        sticky_m[16+c] = 1;
      end else pd[c] = h + 1;
    end
    pe[c] = pd[c] - 1;
  endtask

  task automatic run_to(int target);
    for (int k = 0; k < 300 && cyc < target; k++) tick();
  endtask

  // one CSR transaction with rsp_ready high; reads are expected while channels are idle
  task automatic csr(bit w, logic [31:0] a, logic [31:0] d);
    int off, i;
    bit isp, ist, iss;
    logic [31:0] exp;
    off = int'(a - BASE);
    isp = off >= 0 && off < 4 * PC && off % 4 == 0;
    ist = off == 64;
    iss = off == 68;
    i = isp ? off / 4 : 0;
    exp = w ? 32'h0 : isp ? {me[i], 15'b0, mb[i], ml[i]} : ist ? 32'(tmo_m) : iss ? sticky_m : 32'h0;
    csr_req_valid = 1;
    csr_req_write = w;
    csr_req_addr = a;
    csr_req_wdata = d;
    chk("csr_req_ready", 32'(csr_req_ready), 1);
    tick();
    chk("csr_rsp_valid", 32'(csr_rsp_valid), 1);
    chk("csr_rsp_rdata", csr_rsp_rdata, exp);
    chk("csr_rsp_fault", 32'(csr_rsp_fault), 32'(!(isp || ist || iss)));
    chk("csr_side_effect", 32'(csr_rsp_side_effect), 32'(w));
    tick();
    chk("csr_rsp_drop", 32'(csr_rsp_valid), 0);
    if (w && isp) begin
      ml[i] = d[7:0]; mb[i] = d[15:8]; me[i] = d[31];
    end
    if (w && ist) tmo_m = int'(d[15:0]);
    if (w && iss) sticky_m = sticky_m & ~(d & 32'h0003_0000);
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    chk("rst_rsp_valid", 32'(csr_rsp_valid), 0);
    chk("rst_rsp_rdata", csr_rsp_rdata, 0);
    chk("rst_rsp_fault", 32'(csr_rsp_fault), 0);
    chk("rst_rsp_side", 32'(csr_rsp_side_effect), 0);
    rst_n = 1;
    tick();
    // lead count of 5, then back-to-back burst of 2
    csr(1, BASE + 12, 32'h0000_0205);
    csr(1, BASE + 32'h40, 0);
    csr(0, BASE + 12, 0);
    issue(0, 3, 0, 0);
    run_to(pd[0]);
    issue(0, 3, 1, 0);
    run_to(pd[0]);
    tick();
    // external stretch released after 10 low cycles, no timeout
    csr(1, BASE + 4, 32'h8000_0002);
    issue(0, 1, 0, 10);
    run_to(pd[0]);
    tick();
    // timeout of 4 with ext_wait_n stuck low; sticky bit then cleared
    csr(1, BASE + 32'h40, 4);
    issue(0, 1, 0, 30);
    run_to(pd[0]);
    tick();
    csr(0, BASE + 32'h44, 0);
    csr(1, BASE + 32'h44, 32'h0001_0000);
    csr(0, BASE + 32'h44, 0);
    // independent channels: LEAD=0 on ch0, LEAD=7 on ch1
    csr(1, BASE + 0, 0);
    csr(1, BASE + 8, 7);
    issue(0, 0, 0, 0);
    issue(1, 2, 0, 0);
    run_to(pd[1]);
    tick();
    // reserved profile bits read 0; unmapped write changes nothing
    csr(1, BASE + 20, 32'hffff_ffff);
    csr(0, BASE + 20, 0);
    csr(1, BASE + 32'h48, 32'hffff_ffff);
    csr(0, BASE + 32'h40, 0);
    // unmapped read with the response held for 3 cycles
    csr_rsp_ready = 0;
    csr_req_valid = 1;
    csr_req_write = 0;
    csr_req_addr = BASE + 32'h48;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_rsp_valid", 32'(csr_rsp_valid), 1);
      chk("hold_rsp_fault", 32'(csr_rsp_fault), 1);
      chk("hold_rsp_rdata", csr_rsp_rdata, 0);
      chk("hold_req_ready", 32'(csr_req_ready), 0);
      if (i < 2) tick();
    end
    csr_rsp_ready = 1;
    tick();
    chk("hold_rsp_drop", 32'(csr_rsp_valid), 0);
    // reset in the middle of a count: no done pulse, registers cleared
    issue(0, 3, 0, 0);
    tick();
    tick();
    rst_n = 0;
    model_reset();
    tick();
    chk("midrst_rsp_valid", 32'(csr_rsp_valid), 0);
    rst_n = 1;
    repeat (8) tick();
    csr(0, BASE + 12, 0);
    // randomized profiles, timeout and request traffic
    for (int i = 0; i < PC; i++)
      csr(1, BASE + 32'(4 * i), {1'($urandom_range(0, 1)), 15'b0, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))});
    csr(1, BASE + 32'h40, 32'($urandom_range(0, 5)));
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < CH; c++)
        if (!(cyc >= ps[c] && cyc <= pe[c]) && $urandom_range(0, 2) == 0)
          issue(c, $urandom_range(0, PC - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 9));
      tick();
    end
    run_to(pd[0] > pd[1] ? pd[0] : pd[1]);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
